// File: rtl/mc_control_fsm.sv
// -----------------------------------------------------------------------------
// mc_control_fsm
//   Moore control unit for the multicycle processor. It walks each instruction
//   through fetch / decode / execute / memory / write-back, one state per clock,
//   and drives the datapath write enables, memory strobes and mux/ALU selects.
//
//   Optional feature macro: MCP_ADDI_EN
//     defined   - opcode 0x08 (addi) runs DECODE -> EXECI -> IMMWB -> FETCH.
//     undefined - EXECI/IMMWB are not built and 0x08 is an illegal opcode.
//
// Ports
//   i_clk            system clock, rising edge
//   i_reset          synchronous active-high reset; gates every output to 0
//                    in the cycle it is high
//   i_opcode[5:0]    IR[31:26], looked at only in DECODE and MEMADDR
//   i_zero           ALU zero flag (combinational from the datapath)
//   o_pc_write, o_pc_write_cond, o_iord, o_mem_read, o_mem_write,
//   o_mem_to_reg, o_ir_write, o_alu_src_a, o_reg_write, o_reg_dst
//                    single-bit datapath controls
//   o_pc_en          PCWrite | (PCWriteCond & Zero), the PC register's write
//   o_pc_source[1:0] 00 ALU result, 01 ALUOut, 10 jump target
//   o_alu_op[1:0]    00 add, 01 subtract, 10 funct-decoded
//   o_alu_src_b[1:0] 00 regB, 01 constant 4, 10 sign-ext imm, 11 imm<<2
//   o_state[3:0]     current state code (debug)
//   o_illegal        sticky flag: an unsupported opcode was decoded
// -----------------------------------------------------------------------------
module mc_control_fsm (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [5:0] i_opcode,
    input  logic       i_zero,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_mem_to_reg,
    output logic       o_ir_write,
    output logic       o_alu_src_a,
    output logic       o_reg_write,
    output logic       o_reg_dst,
    output logic       o_pc_en,
    output logic [1:0] o_pc_source,
    output logic [1:0] o_alu_op,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_state,
    output logic       o_illegal
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9
`ifdef MCP_ADDI_EN
        ,
        S_EXECI   = 4'd10,
        S_IMMWB   = 4'd11
`endif
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

    state_t r_state;
    ctrl_t  r_ctrl;
    logic   r_illegal;

    state_t w_state_next;
    logic   w_illegal_set;
    logic   w_run;

    // Moore output table for one state.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE: c.alu_src_b = 2'b11;
            S_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
            end
            S_RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
`ifdef MCP_ADDI_EN
            S_EXECI: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_IMMWB: c.reg_write = 1'b1;
`endif
            default: c = '0;
        endcase
        return c;
    endfunction

    // Next-state logic. Anything not listed (including unbuilt codes)
    // falls back to FETCH.
    always_comb begin
        w_state_next  = S_FETCH;
        w_illegal_set = 1'b0;
        case (r_state)
            S_FETCH: w_state_next = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_RTYPE:      w_state_next = S_EXEC;
                    OP_LW, OP_SW:  w_state_next = S_MEMADDR;
                    OP_BEQ:        w_state_next = S_BRANCH;
                    OP_J:          w_state_next = S_JUMP;
`ifdef MCP_ADDI_EN
                    OP_ADDI:       w_state_next = S_EXECI;
`endif
                    default: begin
                        w_state_next  = S_FETCH;
                        w_illegal_set = 1'b1;
                    end
                endcase
            end
            // Opcode is re-examined here to pick the load or store leg; an
            // opcode that changed to neither simply abandons the access.
            S_MEMADDR: begin
                if (i_opcode == OP_LW)
                    w_state_next = S_MEMRD;
                else if (i_opcode == OP_SW)
                    w_state_next = S_MEMWR;
                else
                    w_state_next = S_FETCH;
            end
            S_MEMRD: w_state_next = S_MEMWB;
            S_EXEC:  w_state_next = S_RWB;
`ifdef MCP_ADDI_EN
            S_EXECI: w_state_next = S_IMMWB;
`endif
            default: w_state_next = S_FETCH;
        endcase
    end

    // State and outputs are registered together: the output register holds
    // the decode of the state being entered, so outputs stay a pure function
    // of the current state while coming straight from flops.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_ctrl    <= ctrl_of(S_FETCH);
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= ctrl_of(w_state_next);
            if (w_illegal_set)
                r_illegal <= 1'b1;
        end
    end

    // Reset gates every output in the same cycle so no write can slip
    // through while the machine is being restarted.
    assign w_run = ~i_reset;

    assign o_pc_write      = w_run & r_ctrl.pc_write;
    assign o_pc_write_cond = w_run & r_ctrl.pc_write_cond;
    assign o_iord          = w_run & r_ctrl.iord;
    assign o_mem_read      = w_run & r_ctrl.mem_read;
    assign o_mem_write     = w_run & r_ctrl.mem_write;
    assign o_mem_to_reg    = w_run & r_ctrl.mem_to_reg;
    assign o_ir_write      = w_run & r_ctrl.ir_write;
    assign o_alu_src_a     = w_run & r_ctrl.alu_src_a;
    assign o_reg_write     = w_run & r_ctrl.reg_write;
    assign o_reg_dst       = w_run & r_ctrl.reg_dst;
    assign o_pc_source     = w_run ? r_ctrl.pc_source : 2'b00;
    assign o_alu_op        = w_run ? r_ctrl.alu_op    : 2'b00;
    assign o_alu_src_b     = w_run ? r_ctrl.alu_src_b : 2'b00;
    assign o_pc_en         = w_run & (r_ctrl.pc_write | (r_ctrl.pc_write_cond & i_zero));
    assign o_state         = w_run ? r_state : 4'd0;
    assign o_illegal       = w_run & r_illegal;

endmodule

// File: tb/tb_mc_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm
//   Table-driven bench for mc_control_fsm: each record gives one cycle's
//   inputs and the state/control outputs expected during that cycle. A short
//   hand-written loop then measures cycles-per-instruction per opcode.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic       zero = 1'b0;

    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       mem_to_reg, ir_write, alu_src_a, reg_write, reg_dst, pc_en;
    logic [1:0] pc_source, alu_op, alu_src_b;
    logic [3:0] state;
    logic       illegal;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_opcode       (opcode),
        .i_zero         (zero),
        .o_pc_write     (pc_write),
        .o_pc_write_cond(pc_write_cond),
        .o_iord         (iord),
        .o_mem_read     (mem_read),
        .o_mem_write    (mem_write),
        .o_mem_to_reg   (mem_to_reg),
        .o_ir_write     (ir_write),
        .o_alu_src_a    (alu_src_a),
        .o_reg_write    (reg_write),
        .o_reg_dst      (reg_dst),
        .o_pc_en        (pc_en),
        .o_pc_source    (pc_source),
        .o_alu_op       (alu_op),
        .o_alu_src_b    (alu_src_b),
        .o_state        (state),
        .o_illegal      (illegal)
    );

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       pc_en;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       illegal;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       z;
        logic [3:0] st;
        obs_t       exp;
    } vec_t;

    vec_t vecs[$];
    logic cur_ill;
    int   total = 0;
    int   bad = 0;

    obs_t act;
    assign act = {pc_write, pc_write_cond, iord, mem_read, mem_write, mem_to_reg,
                  ir_write, alu_src_a, reg_write, reg_dst, pc_en, pc_source,
                  alu_op, alu_src_b, illegal};

    // Expected outputs for a state, straight from the output table.
    function automatic obs_t table_out(input int s, input logic z);
        obs_t e;
        e = '0;
        case (s)
            0:  begin e.mem_read = 1; e.ir_write = 1; e.pc_write = 1; e.pc_en = 1; e.alu_src_b = 2'b01; end
            1:  e.alu_src_b = 2'b11;
            2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            3:  begin e.mem_read = 1; e.iord = 1; end
            4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
            5:  begin e.mem_write = 1; e.iord = 1; end
            6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
            7:  begin e.reg_write = 1; e.reg_dst = 1; end
            8:  begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1; e.pc_source = 2'b01; e.pc_en = z; end
            9:  begin e.pc_write = 1; e.pc_source = 2'b10; e.pc_en = 1; end
            10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
            11: e.reg_write = 1;
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic v(input logic rst, input logic [5:0] op, input logic z, input int st);
        vec_t r;
        r.rst = rst;
        r.op  = op;
        r.z   = z;
        r.st  = rst ? 4'd0 : 4'(st);
        r.exp = rst ? '0 : table_out(st, z);
        r.exp.illegal = cur_ill & ~rst;
        vecs.push_back(r);
    endtask

    task automatic check_cpi(input logic [5:0] op, input int want);
        int n;
        bit done;
        opcode = op;
        n = 1;
        done = 0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk); #1;
            if (state == 4'd0) done = 1;
            else n++;
        end
        total++;
        if (!done || n != want) begin
            bad++;
            $display("FAIL cpi op=%02h got %0d cycles (done=%0b) want %0d", op, n, done, want);
        end else
            $display("cpi op=%02h cycles=%0d", op, n);
    endtask

    initial begin
        cur_ill = 0;
        // Reset held two cycles
        v(1, 6'h00, 0, 0); v(1, 6'h00, 0, 0);
        // lw
        v(0, 6'h23, 0, 0); v(0, 6'h23, 0, 1); v(0, 6'h23, 0, 2); v(0, 6'h23, 0, 3); v(0, 6'h23, 0, 4);
        // beq taken / not taken
        v(0, 6'h04, 1, 0); v(0, 6'h04, 1, 1); v(0, 6'h04, 1, 8);
        v(0, 6'h04, 0, 0); v(0, 6'h04, 0, 1); v(0, 6'h04, 0, 8);
        // R-type; opcode changed during EXEC must be ignored
        v(0, 6'h00, 0, 0); v(0, 6'h00, 0, 1); v(0, 6'h2B, 0, 6); v(0, 6'h2B, 0, 7);
        // sw interrupted by reset in MEMADDR, then a full sw
        v(0, 6'h2B, 0, 0); v(0, 6'h2B, 0, 1); v(1, 6'h2B, 0, 2);
        v(0, 6'h2B, 0, 0); v(0, 6'h2B, 0, 1); v(0, 6'h2B, 0, 2); v(0, 6'h2B, 0, 5);
        // addi
        v(0, 6'h08, 0, 0); v(0, 6'h08, 0, 1);
`ifdef MCP_ADDI_EN
        v(0, 6'h08, 0, 10); v(0, 6'h08, 0, 11);
`else
        cur_ill = 1;
`endif
        v(0, 6'h08, 0, 0);
        // reset clears Illegal
        v(1, 6'h00, 0, 0);
        cur_ill = 0;
        // illegal opcode, then j with Illegal still set
        v(0, 6'h3F, 0, 0); v(0, 6'h3F, 0, 1);
        cur_ill = 1;
        v(0, 6'h02, 0, 0); v(0, 6'h02, 0, 1); v(0, 6'h02, 0, 9); v(0, 6'h02, 0, 0);
        v(1, 6'h02, 0, 0);
        cur_ill = 0;
        v(0, 6'h00, 0, 0);

        // Each record: drive after the falling edge, check just after that.
        foreach (vecs[i]) begin
            @(negedge clk);
            reset  = vecs[i].rst;
            opcode = vecs[i].op;
            zero   = vecs[i].z;
            #1;
            total++;
            if (state !== vecs[i].st) begin
                bad++;
                $display("FAIL vec%0d state got %0d want %0d", i, state, vecs[i].st);
            end
            total++;
            if (act !== vecs[i].exp) begin
                bad++;
                $display("FAIL vec%0d ctrl got %05h want %05h (state %0d)", i, act, vecs[i].exp, state);
            end else
                $display("vec%0d rst=%0b op=%02h z=%0b state=%0d ctrl=%05h", i, vecs[i].rst,
                         vecs[i].op, vecs[i].z, state, act);
        end

        // Cycles per instruction, each measured from a FETCH cycle.
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        check_cpi(6'h00, 4);
        check_cpi(6'h23, 5);
        check_cpi(6'h2B, 4);
        check_cpi(6'h04, 3);
        check_cpi(6'h02, 3);
`ifdef MCP_ADDI_EN
        check_cpi(6'h08, 4);
`else
        check_cpi(6'h08, 2);
`endif
        check_cpi(6'h3F, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Main control unit for the multicycle processor: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It drives the write enables of the datapath's `nbit_reg` instances (PC, IR), the memory strobes, the register-file write and all mux/ALU selects, one state per clock. It sits beside the datapath and consumes only the IR opcode field and the ALU Zero flag.

## Interface
- No parameters. Widths are fixed by the ISA subset.
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high; forces state to FETCH at the next rising edge.
- Opcode  in  6  IR[31:26], valid from DECODE onward.
- Zero  in  1  ALU zero flag, combinational from datapath.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls.
- PCEn  out  1  = PCWrite | (PCWriteCond & Zero); drives the PC register's Write.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded.
- ALUSrcB  out  2  00 regB, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- State  out  4  current state code, for debug.
- Illegal  out  1  sticky: an unsupported opcode was decoded.

## Operation
- State codes: 0 FETCH, 1 DECODE, 2 MEMADDR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB, 8 BRANCH, 9 JUMP, 10 EXECI, 11 IMMWB. Codes 12–15 are unreachable and go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE→ by opcode: 0x00 EXEC, 0x23/0x2B MEMADDR, 0x04 BRANCH, 0x02 JUMP, 0x08 EXECI (macro only), any other FETCH.
  - MEMADDR→MEMRD (0x23) or MEMWR (0x2B).
  - MEMRD→MEMWB.
  - EXEC→RWB.
  - EXECI→IMMWB.
  - MEMWB, MEMWR, RWB, BRANCH, JUMP, IMMWB→FETCH.
- Outputs per state. Any output not listed is 0.
  - FETCH: MemRead, IRWrite, PCWrite=1; ALUSrcB=01.
  - DECODE: ALUSrcB=11.
  - MEMADDR, EXECI: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - IMMWB: RegWrite=1.
- Illegal is set at the edge leaving DECODE with an unsupported opcode. It stays set until Reset.
- Reset mid-instruction abandons that instruction; the next state is FETCH regardless of the current state.

## Timing
- Outputs are a combinational decode of the state register (Moore); PCEn additionally depends on Zero within the cycle.
- While Reset=1, all outputs are gated to 0 in that same cycle, so no register or memory write occurs. State remains 0; Illegal is 0.
- Cycles per instruction, counted from entry to FETCH until the next FETCH:
  - R-type: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - j: 3
  - addi: 4
  - illegal opcode: 2
- Opcode is sampled only in DECODE and MEMADDR. Changes at other times are ignored.

## Configuration
- MCP_ADDI_EN defined: opcode 0x08 goes DECODE→EXECI→IMMWB→FETCH. The instruction takes 4 cycles and writes rt with rs+imm.
- MCP_ADDI_EN undefined: states 10 and 11 are not built. Opcode 0x08 is illegal: it returns to FETCH after DECODE and sets Illegal.

## Test plan
- Reset held for 2 cycles, then released. While Reset=1: State=0 and all outputs 0. On the first cycle after release: PCEn=1, IRWrite=1, MemRead=1, ALUSrcB=01.
- Opcode 0x23 (lw). Required State sequence: 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4; IorD=1 in state 3.
- Opcode 0x04 (beq), run twice: once with Zero=1, once with Zero=0. Required State sequence: 0,1,8,0. PCEn=1 in state 8 only when Zero=1; PCSource=01 in both runs.
- Opcode 0x2B (sw) with Reset asserted in state 2 (MEMADDR). Next state is 0; MemWrite is never asserted.
- Opcode 0x3F. Required State sequence: 0,1,0; Illegal=1 from then on and cleared only by Reset. Then opcode 0x02 (j): State sequence 0,1,9,0 with PCEn=1 and PCSource=10 in state 9.
- Opcode 0x08, run in both builds. With MCP_ADDI_EN: State sequence 0,1,10,11,0, with RegWrite=1 and RegDst=0 in state 11. Without it: State sequence 0,1,0 and Illegal=1.
